// File: rtl/button_event_gen.sv
// Per-button event generator: turns a debounced level into press/release/long-press/repeat pulses.
// Define BUTTON_EVENT_REPEAT_EN to build the auto-repeat counter in HOLD; otherwise repeat_pulse stays 0.
//
// state | meaning
// IDLE  | button released, waiting for sw_in high
// PRESS | pressed, counting towards long_cycles
// HOLD  | long press reached, waiting for release (and repeating if enabled)
module button_event_gen #(
    parameter int               width         = 16,
    parameter logic [width-1:0] long_cycles   = 16'd50000,
    parameter logic [width-1:0] repeat_cycles = 16'd12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_in,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [width-1:0] long_last = long_cycles - 1'b1;

    // Thresholds below 2 would make the terminal compare fire on the first counted edge.
    if (long_cycles < 2) begin : g_long_chk
        $error("button_event_gen: long_cycles must be >= 2");
    end
    if (repeat_cycles < 2) begin : g_rep_chk
        $error("button_event_gen: repeat_cycles must be >= 2");
    end

    state_t           state;
    logic [width-1:0] cnt;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [width-1:0] repeat_last = repeat_cycles - 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sw_in) begin
                        state       <= PRESS;
                        cnt         <= '0;
                        press       <= 1'b1;
                        held        <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end
                end
                PRESS: begin
                    // Release wins over a same-edge threshold hit.
                    if (!sw_in) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == long_last) begin
                        state      <= HOLD;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!sw_in) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end
`ifdef BUTTON_EVENT_REPEAT_EN
                    else if (cnt == repeat_last) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

`ifndef BUTTON_EVENT_REPEAT_EN
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed scenarios plus random sw_in runs against a hold-age event model.
module tb_button_event_gen;

    localparam int L = 10;
    localparam int R = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit rep_en = 1'b1;
`else
    localparam bit rep_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_in = 1'b0;
    logic       press, release_pulse, long_press, repeat_pulse, held;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: hold age counts edges with sw_in high since the press edge
    bit m_held = 0;
    int m_age = 0;
    int m_count = 0;
    bit e_press, e_release, e_long, e_repeat;

    int seen_press, seen_release, seen_long, seen_repeat;

    button_event_gen #(
        .width        (16),
        .long_cycles  (16'(L)),
        .repeat_cycles(16'(R))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_in        (sw_in),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("press", 32'(press), 32'(e_press));
        check("release", 32'(release_pulse), 32'(e_release));
        check("long_press", 32'(long_press), 32'(e_long));
        check("repeat", 32'(repeat_pulse), 32'(e_repeat));
        check("held", 32'(held), 32'(m_held));
        check("press_count", 32'(press_count), 32'(m_count % 256));
    endtask

    task automatic model_clear();
        m_held = 0; m_age = 0; m_count = 0;
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
    endtask

    // drive one level for one clock edge, then predict and compare
    task automatic step(input logic s);
        sw_in = s;
        @(posedge clk);
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        if (!m_held && s) begin
            m_held = 1; m_age = 0; m_count++; e_press = 1;
        end else if (m_held && s) begin
            m_age++;
            e_long   = (m_age == L);
            e_repeat = rep_en && (m_age > L) && (((m_age - L) % R) == 0);
        end else if (m_held && !s) begin
            m_held = 0; e_release = 1;
        end
        #1;
        compare_all();
        seen_press   += int'(press);
        seen_release += int'(release_pulse);
        seen_long    += int'(long_press);
        seen_repeat  += int'(repeat_pulse);
    endtask

    task automatic clear_seen();
        seen_press = 0; seen_release = 0; seen_long = 0; seen_repeat = 0;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        #1;
        model_clear();
        compare_all();
        repeat (cycles) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        clear_seen();
        // 1: reset then idle
        reset = 1'b1;
        sw_in = 1'b0;
        apply_reset(3);
        for (int i = 0; i < 5; i++) step(1'b0);

        // 2: short press of 5 cycles
        clear_seen();
        for (int i = 0; i < 5; i++) step(1'b1);
        step(1'b0);
        check("s2_long_cnt", 32'(seen_long), 32'd0);
        check("s2_press_cnt", 32'(seen_press), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0);

        // 3: 20-cycle hold
        clear_seen();
        for (int i = 0; i < 20; i++) step(1'b1);
        step(1'b0);
        check("s3_long_cnt", 32'(seen_long), 32'd1);
        check("s3_repeat_cnt", 32'(seen_repeat), rep_en ? 32'd2 : 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0);

        // 4: release exactly on the long-press edge
        clear_seen();
        for (int i = 0; i < 10; i++) step(1'b1);
        step(1'b0);
        check("s4_long_cnt", 32'(seen_long), 32'd0);
        check("s4_release_cnt", 32'(seen_release), 32'd1);
        step(1'b0);

        // 5: 257 short presses wrap the counter
        apply_reset(1);
        clear_seen();
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 3; i++) step(1'b1);
            for (int i = 0; i < 3; i++) step(1'b0);
        end
        check("s5_count_wrap", 32'(press_count), 32'd1);
        check("s5_press_cnt", 32'(seen_press), 32'd257);
        check("s5_release_cnt", 32'(seen_release), 32'd257);

        // 6: reset while in HOLD with the button still down
        apply_reset(1);
        for (int i = 0; i < 13; i++) step(1'b1);
        check("s6_in_hold", 32'(held), 32'd1);
        sw_in = 1'b1;
        apply_reset(2);
        step(1'b1);
        check("s6_repress", 32'(press), 32'd1);
        check("s6_count", 32'(press_count), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1);
        step(1'b0);

        // random runs of high/low levels, including 1-cycle glitches
        for (int r = 0; r < 200; r++) begin
            int len;
            logic lvl;
            lvl = logic'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 25));
            for (int i = 0; i < len; i++) step(lvl);
            if ($urandom_range(0, 30) == 0) apply_reset(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Consumes the debounced, synchronized level from the per-button debouncer and turns it into single-cycle events for the game logic.
- Events: press, release, long-press and auto-repeat.
- Also outputs a held level and a wrapping press counter.
- One instance per button, between the debouncer and the game FSM / 7-segment score logic.

Parameters:
width, 16, bit width of the hold/repeat cycle counter
long_cycles, 16'd50000, clk cycles sw_in must stay high after the press event before long_press fires (legal range 2 .. 2^width-1)
repeat_cycles, 16'd12500, clk cycles between successive repeat pulses after long_press (legal range 2 .. 2^width-1)

Ports:
clk          input   1  system clock
reset        input   1  asynchronous, active-high reset
sw_in        input   1  debounced, synchronized button level (1 = pressed)
press        output  1  one-cycle pulse on press
release      output  1  one-cycle pulse on release
long_press   output  1  one-cycle pulse when hold reaches long_cycles
repeat       output  1  one-cycle pulse every repeat_cycles while held past long_press
held         output  1  level: 1 while FSM is not IDLE
press_count  output  8  number of press events, wraps 255 -> 0

Behaviour:
- One clock and one reset: clk, reset. Reset is asynchronous and active-high.
- All outputs are registered. On reset: every output is 0, the FSM is IDLE and cnt = 0.
- States: IDLE, PRESS, HOLD.
- Pulse outputs default to 0 every cycle and are set only on the edges listed below.
- IDLE, at an edge with sw_in=1:
  - next state PRESS, cnt <= 0, press <= 1, press_count <= press_count+1.
  - press is visible for the cycle after that edge (edge N below).
- PRESS, at an edge with sw_in=1:
  - if cnt == long_cycles-1: next state HOLD, cnt <= 0, long_press <= 1.
  - otherwise cnt <= cnt+1.
  - Result: long_press fires at edge N+long_cycles.
- HOLD, at an edge with sw_in=1:
  - if cnt == repeat_cycles-1: cnt <= 0, repeat <= 1.
  - otherwise cnt <= cnt+1.
  - Result: repeats fire at N+long_cycles+k*repeat_cycles, k >= 1.
- PRESS or HOLD, at an edge with sw_in=0: next state IDLE, cnt <= 0, release <= 1.
- Release takes priority over a same-edge threshold hit. No long_press or repeat pulse is emitted on the release edge.
- Press and release are never asserted in the same cycle.
- held is 1 from the cycle press is asserted until the cycle release is asserted; it is 0 during the release cycle.
- A 1-cycle low on sw_in gives a release pulse then a press pulse on consecutive cycles. No filtering is done here; the debouncer prevents this case.
- Reset mid-operation:
  - Immediately forces IDLE, clears all outputs and cnt; pending pulses are dropped.
  - If sw_in is still 1 after reset deasserts, a new press event follows on the first edge.
- press_count is 8 bits and wraps modulo 256 with no saturation or flag.
- cnt never exceeds max(long_cycles, repeat_cycles)-1. No overflow is possible within the legal parameter range.

Optional Feature:
Macro: BUTTON_EVENT_REPEAT_EN
- Defined: HOLD generates repeat pulses as described above.
- Not defined:
  - repeat is tied to 0 and the HOLD counter logic is not built.
  - HOLD simply waits for release.
  - All other outputs behave identically.

Test Plan:
All scenarios use long_cycles=10 and repeat_cycles=4; N is the press edge.
1. Reset held 3 cycles, sw_in=0, then release reset and idle 5 cycles -> all outputs 0, press_count=0.
2. sw_in high 5 cycles, then low -> press at N only, release at N+5, no long_press, held high for 5 cycles, press_count=1.
3. sw_in high 20 cycles with REPEAT_EN defined -> long_press at N+10, repeat at N+14 and N+18, release at N+20. With the macro undefined -> repeat never asserts; the rest is identical.
4. sw_in falls exactly at edge N+10 -> release at N+10, long_press never asserted, state IDLE.
5. 257 short presses, each 3 cycles high / 3 cycles low -> press_count reads 1 after wrap (255 -> 0 -> 1), 257 press and 257 release pulses.
6. Assert reset at N+12 while in HOLD, then deassert with sw_in still 1 -> outputs 0 during reset, new press pulse on the first edge after deassert, press_count=1.
